// File: rtl/booth_seq_mul.sv
// Radix-2 Booth sequential signed multiplier: WIDTH CALC cycles, then one DONE cycle.
// start is ignored while busy; a new start in DONE chains the next operation with no bubble.
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, m, sum, acc_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             q1, q1_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth step: add/subtract M per {Q0,Q-1}, then arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    sum = acc;
    case ({q[0], q1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    q1_nxt  = q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      q   <= '0;
      q1  <= 1'b0;
      cnt <= '0;
      p   <= '0;
    end else if (accept) begin
      m   <= {a[WIDTH-1], a};
      acc <= '0;
      q   <= b;
      q1  <= 1'b0;
      cnt <= CW'(WIDTH);
    end else if (state == CALC) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      q1  <= q1_nxt;
      cnt <= cnt - CW'(1);
      // The extra accumulator bit is pure sign; the product is the low 2*WIDTH bits.
      if (last) p <= {acc_nxt[WIDTH-1:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul at WIDTH=4 (directed, exhaustive, reset abort) and WIDTH=8 (random).
module tb_booth_seq_mul;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy4, done4, busy8, done8;
  logic [7:0] p4;
  logic [15:0] p8;

  int n_chk = 0;
  int n_fail = 0;
  int n_done4 = 0;
  int n_done8 = 0;

  booth_seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted start yields a*b after WIDTH busy cycles.
  bit     m4_busy = 0, m4_done = 0, m8_busy = 0, m8_done = 0;
  int     m4_cnt = 0, m8_cnt = 0;
  longint m4_p = 0, m4_pend = 0, m8_p = 0, m8_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_busy = 0; m4_done = 0; m4_p = 0; m4_cnt = 0;
      m8_busy = 0; m8_done = 0; m8_p = 0; m8_cnt = 0;
    end else begin
      if (m4_busy) begin
        m4_cnt--;
        if (m4_cnt == 0) begin m4_busy = 0; m4_done = 1; m4_p = m4_pend; end
      end else begin
        m4_done = 0;
        if (start4) begin
          m4_busy = 1; m4_cnt = 4;
          m4_pend = longint'($signed(a4)) * longint'($signed(b4));
        end
      end
      if (m8_busy) begin
        m8_cnt--;
        if (m8_cnt == 0) begin m8_busy = 0; m8_done = 1; m8_p = m8_pend; end
      end else begin
        m8_done = 0;
        if (start8) begin
          m8_busy = 1; m8_cnt = 8;
          m8_pend = longint'($signed(a8)) * longint'($signed(b8));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done4) n_done4++;
    if (done8) n_done8++;
    chk("busy4", longint'(busy4), longint'(m4_busy));
    chk("done4", longint'(done4), longint'(m4_done));
    chk("p4", longint'($signed(p4)), m4_p);
    chk("busy8", longint'(busy8), longint'(m8_busy));
    chk("done8", longint'(done8), longint'(m8_done));
    chk("p8", longint'($signed(p8)), m8_p);
  end

  // One WIDTH=4 operation; optionally re-pulses start and scrambles operands mid-CALC.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input longint expp,
                      input bit disturb, input string nm);
    int lat;
    int nd;
    lat = -1;
    nd = 0;
    @(negedge clk);
    start4 = 1'b1; a4 = ta; b4 = tb_v;
    @(posedge clk);
    @(negedge clk);
    start4 = disturb; a4 = 4'($urandom); b4 = 4'($urandom);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        if (nd == 0) begin
          lat = n;
          chk({nm, "_p"}, longint'($signed(p4)), expp);
        end
        nd++;
      end
      @(negedge clk);
      if (n == 1) start4 = 1'b0;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_done_count"}, nd, 1);
    chk({nm, "_p_held"}, longint'($signed(p4)), expp);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'h7f;
      2: return 8'h00;
      3: return 8'hff;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("reset_busy4", longint'(busy4), 0);
    chk("reset_done4", longint'(done4), 0);
    chk("reset_p4", longint'(p4), 0);
    chk("reset_p8", longint'(p8), 0);
    rst_n = 1'b1;

    fork
      begin
        run4(4'd3, 4'd2, 6, 1'b0, "mul_3x2");

        // Asynchronous reset in the middle of CALC, between clock edges.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy4", longint'(busy4), 0);
        chk("abort_done4", longint'(done4), 0);
        chk("abort_p4", longint'(p4), 0);
        chk("abort_busy8", longint'(busy8), 0);
        chk("abort_p8", longint'(p8), 0);
        d0 = n_done4;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", n_done4 - d0, 0);

        run4(4'd3, 4'd2, 6, 1'b0, "after_reset_3x2");
        run4(4'h8, 4'h8, 64, 1'b0, "mul_m8xm8");
        run4(4'h8, 4'h7, -56, 1'b0, "mul_m8x7");
        run4(4'h7, 4'hf, -7, 1'b0, "mul_7xm1");
        run4(4'h0, 4'h5, 0, 1'b0, "mul_0x5");
        run4(4'd3, 4'd2, 6, 1'b1, "disturbed_3x2");

        // Exhaustive pairs with start held high: one result every WIDTH+1 cycles.
        d0 = n_done4;
        for (int i = 0; i < 256; i++) begin
          @(negedge clk);
          start4 = 1'b1;
          a4 = 4'(i >> 4);
          b4 = 4'(i);
          repeat (4) @(negedge clk);
        end
        @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_done_count", n_done4 - d0, 256);
      end
      begin
        for (int c = 0; c < 30000; c++) begin
          @(negedge clk);
          start8 = ($urandom_range(0, 3) != 0);
          a8 = pick8();
          b8 = pick8();
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("rand8_enough_ops", longint'(n_done8 > 2000), 1);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
